// File: rtl/fixed_point_serial_add.sv
// Digit-serial two's-complement adder: c = a + b + carry_in, D bits per clock, one operation in flight.
// Define FIXED_POINT_SERIAL_ADD_OVERFLOW_EN to add the signed-overflow output and its logic.
module fixed_point_serial_add #(
    parameter int N = 32,
    parameter int D = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         carry_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         carry_out
`ifdef FIXED_POINT_SERIAL_ADD_OVERFLOW_EN
    ,
    output logic         overflow
`endif
);

    localparam int ND = (D > 0) ? N / D : 1;
    localparam int CW = (ND > 1) ? $clog2(ND) : 1;
    localparam int RW = (D < N) ? N - D : 1;

    if (N < 2 || D < 1 || D > N || (N % D) != 0) begin : gBadParams
        $error("fixed_point_serial_add: need N >= 2, 1 <= D <= N and N %% D == 0");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   a_q, a_d, b_q, b_d;
    logic           cy_q, cy_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]  r_q, r_d;
    logic [N-1:0]   c_q, c_d;
    logic           co_q, co_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;

    logic [D:0]     digitSum;
    logic [N-1:0]   resNext;
    logic [RW-1:0]  resShift;
    logic           lastDigit;

    assign digitSum  = {1'b0, a_q[D-1:0]} + {1'b0, b_q[D-1:0]} + {{D{1'b0}}, cy_q};
    assign lastDigit = (cnt_q == CW'(ND - 1));

    // Earlier digits are kept in r_q; the current digit lands on top of them.
    if (D < N) begin : gShift
        assign resNext  = {digitSum[D-1:0], r_q};
        assign resShift = resNext[N-1:D];
    end else begin : gSingle
        assign resNext  = digitSum[D-1:0];
        assign resShift = r_q;
    end

`ifdef FIXED_POINT_SERIAL_ADD_OVERFLOW_EN
    logic ov_q, ov_d;
    logic msbCarryIn;

    // Carry into the top bit, recovered from the top digit's sum and operand bits.
    assign msbCarryIn = digitSum[D-1] ^ a_q[D-1] ^ b_q[D-1];
    assign overflow   = ov_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cy_q        <= 1'b0;
            cnt_q       <= '0;
            r_q         <= '0;
            c_q         <= '0;
            co_q        <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef FIXED_POINT_SERIAL_ADD_OVERFLOW_EN
            ov_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cy_q        <= cy_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            c_q         <= c_d;
            co_q        <= co_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef FIXED_POINT_SERIAL_ADD_OVERFLOW_EN
            ov_q        <= ov_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cy_d        = cy_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        c_d         = c_q;
        co_d        = co_q;
        out_valid_d = out_valid_q;
`ifdef FIXED_POINT_SERIAL_ADD_OVERFLOW_EN
        ov_d        = ov_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d     = a;
                    b_d     = b;
                    cy_d    = carry_in;
                    cnt_d   = '0;
                    r_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                cy_d  = digitSum[D];
                r_d   = resShift;
                a_d   = a_q >> D;
                b_d   = b_q >> D;
                cnt_d = cnt_q + CW'(1);
                if (lastDigit) begin
                    c_d         = resNext;
                    co_d        = digitSum[D];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
`ifdef FIXED_POINT_SERIAL_ADD_OVERFLOW_EN
                    ov_d        = msbCarryIn ^ digitSum[D];
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign carry_out = co_q;

endmodule
